// File: rtl/memory_responder_bytewide.sv
// Device-side responder for the byte-wide external memory pin interface, backed by a 16-bit RAM.
// Define MEMRESP_INPUT_SYNC_EN to pass all inputs through a 2-flop synchronizer before decode.
module memory_responder_bytewide #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned RESP_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       register_enable,
  input  logic       write_enable,
  input  logic       read_enable,
  input  logic       lower_bit,
  input  logic       upper_bit,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] data_oe,
  output logic       lower_ack,
  output logic       upper_ack,
  output logic       proto_err
);

  localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
  localparam logic [7:0]  LatCnt = 8'(RESP_LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  logic [12:0] in_raw, in_s;
  assign in_raw = {register_enable, write_enable, read_enable, lower_bit, upper_bit, data_in};

`ifdef MEMRESP_INPUT_SYNC_EN
  logic [12:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
    end
  end
  assign in_s = sync2_q;
`else
  assign in_s = in_raw;
`endif

  // strb = {reg, wr, rd, lower, upper}
  logic [4:0] strb;
  logic [2:0] en;
  logic [1:0] sel;
  logic [7:0] din;
  logic       valid;
  assign strb  = in_s[12:8];
  assign en    = strb[4:2];
  assign sel   = strb[1:0];
  assign din   = in_s[7:0];
  assign valid = $onehot(en) && $onehot(sel);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wlo_q, wlo_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  oe_q, oe_d;
  logic        lack_q, lack_d;
  logic        uack_q, uack_d;
  logic        perr_q, perr_d;

  logic [15:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] addr_idx;
  logic [15:0] rdata;
  logic        do_act, mem_we;
  logic [2:0]  act_op;
  logic [1:0]  act_sel;

  assign addr_idx = addr_q[ADDR_WIDTH-1:0];
  assign rdata    = mem_q[addr_idx];

  // Upper address bits are architecturally visible but do not select RAM words.
  logic unused_addr;
  assign unused_addr = ^addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wlo_d   = wlo_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    lack_d  = lack_q;
    uack_d  = uack_q;
    perr_d  = perr_q;
    do_act  = 1'b0;
    mem_we  = 1'b0;
    act_op  = op_q;
    act_sel = sel_q;

    unique case (state_q)
      StIdle: begin
        if (valid) begin
          op_d    = en;
          sel_d   = sel;
          act_op  = en;
          act_sel = sel;
          if (LatCnt == 8'd0) begin
            do_act  = 1'b1;
            state_d = StAck;
          end else begin
            cnt_d   = LatCnt;
            state_d = StWait;
          end
        end else if (strb != 5'd0) begin
          perr_d = 1'b1;
        end
      end
      StWait: begin
        if (strb != {op_q, sel_q}) begin
          perr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            do_act  = 1'b1;
            state_d = StAck;
          end
        end
      end
      StAck: begin
        // Four-phase: release only once the captured enable has gone low.
        if ((en & op_q) == 3'd0) begin
          lack_d  = 1'b0;
          uack_d  = 1'b0;
          oe_d    = 8'h00;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_act) begin
      lack_d = act_sel[1];
      uack_d = act_sel[0];
      unique case (1'b1)
        act_op[2]: begin
          if (act_sel[1]) addr_d[7:0]  = din;
          else            addr_d[15:8] = din;
        end
        act_op[1]: begin
          if (act_sel[1]) wlo_d  = din;
          else            mem_we = 1'b1;
        end
        act_op[0]: begin
          dout_d = act_sel[1] ? rdata[7:0] : rdata[15:8];
          oe_d   = 8'hFF;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      op_q    <= 3'd0;
      sel_q   <= 2'd0;
      addr_q  <= 16'd0;
      wlo_q   <= 8'd0;
      dout_q  <= 8'd0;
      oe_q    <= 8'd0;
      lack_q  <= 1'b0;
      uack_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wlo_q   <= wlo_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      lack_q  <= lack_d;
      uack_q  <= uack_d;
      perr_q  <= perr_d;
    end
  end

  // RAM is never cleared; reset only suppresses an in-flight write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[addr_idx] <= {din, wlo_q};
    end
  end

  assign data_out  = dout_q;
  assign data_oe   = oe_q;
  assign lower_ack = lack_q;
  assign upper_ack = uack_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_memory_responder_bytewide.sv
// Directed bench: DUT a uses RESP_LATENCY=2, DUT b uses RESP_LATENCY=0.
module tb_memory_responder_bytewide;

`ifdef MEMRESP_INPUT_SYNC_EN
  localparam int SyncExtra = 2;
`else
  localparam int SyncExtra = 0;
`endif

  // {reg, wr, rd, lower, upper}
  localparam logic [4:0] RegLo = 5'b100_10;
  localparam logic [4:0] RegHi = 5'b100_01;
  localparam logic [4:0] WrLo  = 5'b010_10;
  localparam logic [4:0] WrHi  = 5'b010_01;
  localparam logic [4:0] RdLo  = 5'b001_10;
  localparam logic [4:0] RdHi  = 5'b001_01;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] strb_a, strb_b;
  logic [7:0] din_a, din_b;
  logic [7:0] dout_a, dout_b, oe_a, oe_b;
  logic       lack_a, uack_a, perr_a, lack_b, uack_b, perr_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  memory_responder_bytewide #(.ADDR_WIDTH(8), .RESP_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .register_enable(strb_a[4]), .write_enable(strb_a[3]), .read_enable(strb_a[2]),
    .lower_bit(strb_a[1]), .upper_bit(strb_a[0]), .data_in(din_a),
    .data_out(dout_a), .data_oe(oe_a), .lower_ack(lack_a), .upper_ack(uack_a),
    .proto_err(perr_a)
  );

  memory_responder_bytewide #(.ADDR_WIDTH(8), .RESP_LATENCY(0)) dut_b (
    .clk(clk), .reset(reset),
    .register_enable(strb_b[4]), .write_enable(strb_b[3]), .read_enable(strb_b[2]),
    .lower_bit(strb_b[1]), .upper_bit(strb_b[0]), .data_in(din_b),
    .data_out(dout_b), .data_oe(oe_b), .lower_ack(lack_b), .upper_ack(uack_b),
    .proto_err(perr_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] acks(input int which);
    return (which == 0) ? {lack_a, uack_a} : {lack_b, uack_b};
  endfunction

  function automatic logic [7:0] douts(input int which);
    return (which == 0) ? dout_a : dout_b;
  endfunction

  function automatic logic [7:0] oes(input int which);
    return (which == 0) ? oe_a : oe_b;
  endfunction

  task automatic set_in(input int which, input logic [4:0] s, input logic [7:0] d);
    if (which == 0) begin
      strb_a = s;
      din_a  = d;
    end else begin
      strb_b = s;
      din_b  = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full four-phase transaction; returns the data_out value seen while acked.
  task automatic txn(input int which, input string tag, input logic [4:0] s, input logic [7:0] d,
                     input int hold, output logic [7:0] rdata);
    int         n;
    logic [1:0] ack;
    logic [7:0] oe0;
    logic       stable;
    int         lat;
    lat = (which == 0) ? 2 : 0;
    set_in(which, s, d);
    n = 0;
    do begin
      tick();
      n++;
      ack = acks(which);
    end while (ack == 2'b00 && n < 40);
    check_val({tag, "_lat"}, n, lat + 1 + SyncExtra);
    check_val({tag, "_ack"}, {30'd0, ack}, {30'd0, s[1:0]});
    rdata = douts(which);
    oe0   = oes(which);
    check_val({tag, "_oe"}, {24'd0, oe0}, s[2] ? 32'hFF : 32'h00);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (acks(which) != ack || douts(which) != rdata || oes(which) != oe0) stable = 1'b0;
    end
    if (hold > 0) check_val({tag, "_hold"}, {31'd0, stable}, 32'd1);
    set_in(which, 5'd0, 8'h00);
    n = 0;
    do begin
      tick();
      n++;
    end while (acks(which) != 2'b00 && n < 40);
    check_val({tag, "_drop"}, n, 1 + SyncExtra);
    check_val({tag, "_oe_off"}, {24'd0, oes(which)}, 32'd0);
    tick();
  endtask

  logic [7:0] rd;
  logic       saw_ack;

  initial begin
    reset = 1'b1;
    set_in(0, 5'd0, 8'h00);
    set_in(1, 5'd0, 8'h00);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_val("rst_dout", {24'd0, dout_a}, 32'd0);
    check_val("rst_oe", {24'd0, oe_a}, 32'd0);
    check_val("rst_ack", {30'd0, lack_a, uack_a}, 32'd0);
    check_val("rst_perr", {31'd0, perr_a}, 32'd0);

    // Address 0x1234 selects word 0x34; read back through 0x0034.
    txn(0, "reg_lo34", RegLo, 8'h34, 0, rd);
    txn(0, "reg_hi12", RegHi, 8'h12, 0, rd);
    txn(0, "wr_lo5a", WrLo, 8'h5A, 0, rd);
    txn(0, "wr_hia5", WrHi, 8'hA5, 0, rd);
    txn(0, "reg_hi00", RegHi, 8'h00, 0, rd);
    txn(0, "rd_lo34", RdLo, 8'h00, 0, rd);
    check_val("data_lo34", {24'd0, rd}, 32'h5A);
    txn(0, "rd_hi34", RdHi, 8'h00, 0, rd);
    check_val("data_hi34", {24'd0, rd}, 32'hA5);

    // Round trip at 0x0005 with a long four-phase hold.
    txn(0, "reg_lo05", RegLo, 8'h05, 0, rd);
    txn(0, "wr_locd", WrLo, 8'hCD, 0, rd);
    txn(0, "wr_hiab", WrHi, 8'hAB, 0, rd);
    txn(0, "rd_lo05", RdLo, 8'h00, 10, rd);
    check_val("data_lo05", {24'd0, rd}, 32'hCD);
    txn(0, "rd_hi05", RdHi, 8'h00, 0, rd);
    check_val("data_hi05", {24'd0, rd}, 32'hAB);

    // Illegal combination: reg + rd together.
    saw_ack = 1'b0;
    set_in(0, 5'b101_10, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (acks(0) != 2'b00) saw_ack = 1'b1;
    end
    set_in(0, 5'd0, 8'h00);
    repeat (2 + SyncExtra) tick();
    check_val("illegal_noack", {31'd0, saw_ack}, 32'd0);
    check_val("illegal_perr", {31'd0, perr_a}, 32'd1);
    txn(0, "rd_lo_after_ill", RdLo, 8'h00, 0, rd);
    check_val("data_after_ill", {24'd0, rd}, 32'hCD);

    // Strobe dropped during WAIT of a wr/upper: no ack, no write.
    txn(0, "wr_lo11", WrLo, 8'h11, 0, rd);
    saw_ack = 1'b0;
    set_in(0, WrHi, 8'h22);
    tick();
    set_in(0, 5'd0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (acks(0) != 2'b00) saw_ack = 1'b1;
    end
    check_val("drop_noack", {31'd0, saw_ack}, 32'd0);
    txn(0, "rd_hi_after_drop", RdHi, 8'h00, 0, rd);
    check_val("data_after_drop", {24'd0, rd}, 32'hAB);
    check_val("perr_sticky", {31'd0, perr_a}, 32'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check_val("perr_cleared", {31'd0, perr_a}, 32'd0);

    // Address wrap: write at 0x0103, read at 0x0003.
    txn(0, "reg_lo03", RegLo, 8'h03, 0, rd);
    txn(0, "reg_hi01", RegHi, 8'h01, 0, rd);
    txn(0, "wr_loef", WrLo, 8'hEF, 0, rd);
    txn(0, "wr_hibe", WrHi, 8'hBE, 0, rd);
    txn(0, "reg_hi00b", RegHi, 8'h00, 0, rd);
    txn(0, "rd_lo03", RdLo, 8'h00, 0, rd);
    check_val("wrap_lo", {24'd0, rd}, 32'hEF);
    txn(0, "rd_hi03", RdHi, 8'h00, 0, rd);
    check_val("wrap_hi", {24'd0, rd}, 32'hBE);

    // Reset during WAIT of wr/upper aborts the write.
    txn(0, "wr_lo99", WrLo, 8'h99, 0, rd);
    set_in(0, WrHi, 8'h77);
    tick();
    reset = 1'b1;
    set_in(0, 5'd0, 8'h00);
    tick();
    reset = 1'b0;
    check_val("rstw_dout", {24'd0, dout_a}, 32'd0);
    check_val("rstw_oe", {24'd0, oe_a}, 32'd0);
    check_val("rstw_ack", {30'd0, lack_a, uack_a}, 32'd0);
    check_val("rstw_perr", {31'd0, perr_a}, 32'd0);
    tick();
    txn(0, "reg_lo03b", RegLo, 8'h03, 0, rd);
    txn(0, "rd_lo03b", RdLo, 8'h00, 0, rd);
    check_val("rstw_mem_lo", {24'd0, rd}, 32'hEF);
    txn(0, "rd_hi03b", RdHi, 8'h00, 0, rd);
    check_val("rstw_mem_hi", {24'd0, rd}, 32'hBE);

    // Zero-latency instance, including a stale-wlo upper write.
    txn(1, "b_reg_lo07", RegLo, 8'h07, 0, rd);
    txn(1, "b_wr_lo3c", WrLo, 8'h3C, 0, rd);
    txn(1, "b_wr_hic3", WrHi, 8'hC3, 0, rd);
    txn(1, "b_rd_lo07", RdLo, 8'h00, 3, rd);
    check_val("b_data_lo07", {24'd0, rd}, 32'h3C);
    txn(1, "b_rd_hi07", RdHi, 8'h00, 0, rd);
    check_val("b_data_hi07", {24'd0, rd}, 32'hC3);
    txn(1, "b_reg_lo08", RegLo, 8'h08, 0, rd);
    txn(1, "b_wr_hi55", WrHi, 8'h55, 0, rd);
    txn(1, "b_rd_lo08", RdLo, 8'h00, 0, rd);
    check_val("b_stale_wlo", {24'd0, rd}, 32'h3C);
    txn(1, "b_rd_hi08", RdHi, 8'h00, 0, rd);
    check_val("b_data_hi08", {24'd0, rd}, 32'h55);
    check_val("b_perr", {31'd0, perr_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_responder_bytewide.md
Name: memory_responder_bytewide

Overview:
- Device-side responder for the byte-wide external memory pin interface. It is the other end of the interface driven by the memory controller: it receives control strobes, decodes them, latches address and write bytes, and serves read bytes on an 8-bit bus with per-byte acknowledges.
- It holds an internal 16-bit-word RAM.
- Used as the FPGA/bench stand-in for the external microcontroller memory. It is also the reference model for controller verification.

Parameters:
- ADDR_WIDTH, 8, number of word-address bits used; RAM depth = 2**ADDR_WIDTH words of 16 bits.
- RESP_LATENCY, 2, clock cycles of wait between strobe detection and acknowledge (0..255).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- register_enable  in  1  address-byte strobe
- write_enable  in  1  write-data-byte strobe
- read_enable  in  1  read-data-byte strobe
- lower_bit  in  1  selects low byte
- upper_bit  in  1  selects high byte
- data_in  in  8  bus value driven by controller
- data_out  out  8  bus value driven by responder
- data_oe  out  8  bus output enable, all-ones when driving
- lower_ack  out  1  low-byte acknowledge (drives controller lower_byte_in)
- upper_ack  out  1  high-byte acknowledge (drives controller upper_byte_in)
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; data_out, data_oe, lower_ack, upper_ack, proto_err = 0.
  - Address register = 0; write-low latch = 0. RAM contents are not cleared.
  - Reset asserted mid-transaction aborts it with no RAM side effect.
- Valid request:
  - Exactly one of {register_enable, write_enable, read_enable} is high.
  - Exactly one of {lower_bit, upper_bit} is high.
  - Any other non-zero combination in IDLE is ignored, and proto_err is set.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On a valid request, capture op and byte select. Load counter = RESP_LATENCY and go to WAIT.
  - If RESP_LATENCY = 0, perform the action that cycle and go directly to ACK.
- WAIT:
  - Decrement the counter each cycle.
  - If the strobe combination changes from the captured value: abort, no action, set proto_err, go to IDLE.
  - When the counter reaches 0, perform the action, sampling data_in in that cycle, and go to ACK.
- Actions:
  - reg/lower: addr[7:0] = data_in.
  - reg/upper: addr[15:8] = data_in.
  - wr/lower: wlo = data_in.
  - wr/upper: mem[addr[ADDR_WIDTH-1:0]] = {data_in, wlo}.
  - rd/lower: data_out = mem[addr][7:0]; data_oe = 8'hFF.
  - rd/upper: data_out = mem[addr][15:8]; data_oe = 8'hFF.
- ACK:
  - The ack matching the byte select is high from the first ACK cycle; read data is valid in that same cycle.
  - Four-phase handshake: hold the ack and data until the captured enable strobe goes low.
  - In the cycle after the strobe is seen low: ack = 0, data_oe = 0, go to IDLE.
  - A new request is accepted no earlier than the cycle after returning to IDLE.
- Ack timing: ack rises RESP_LATENCY+1 cycles after the strobe is first sampled high.
- Boundary rules:
  - Address bits above ADDR_WIDTH are ignored, so addresses wrap modulo the depth.
  - wr/upper without a preceding wr/lower uses the stale wlo.
  - Reads of never-written words return X in simulation.
  - lower_ack and upper_ack are never high simultaneously.
  - data_oe is non-zero only in ACK for read ops.
- proto_err clears only on reset.

Optional Feature:
- Macro: MEMRESP_INPUT_SYNC_EN.
- Defined:
  - All control inputs and data_in pass through a 2-flop synchronizer before decode.
  - Ack latency becomes RESP_LATENCY+3 cycles.
  - Strobe-drop detection is delayed by 2 cycles.
- Undefined: inputs are used directly (same clock domain), with latency as stated above.

Test Plan:
- Address load: reg/lower data 0x34, then reg/upper 0x12; RESP_LATENCY=2 → each ack rises 3 cycles after its strobe; internal addr = 0x1234 (word index 0x34 for ADDR_WIDTH=8).
- Write/read round-trip: addr 0x0005; wr/lower 0xCD, wr/upper 0xAB; then rd/lower → data_out=0xCD with data_oe=0xFF while lower_ack is high; rd/upper → data_out=0xAB.
- Four-phase hold: keep read_enable high 10 cycles after ack → ack and data stay stable; drop strobe → ack=0 and data_oe=0 next cycle.
- Protocol error: register_enable and read_enable high together, or strobe dropped during WAIT → no ack, RAM unchanged, proto_err=1 until reset.
- Wrap and reset: write 0xBEEF at addr 0x0103, read back at 0x0003 → 0xBEEF; assert reset during WAIT of a wr/upper → no write, all outputs 0, RAM word unchanged.
- RESP_LATENCY=0 (and MEMRESP_INPUT_SYNC_EN defined) → ack 1 cycle after strobe sampled (3 cycles with sync); data correct.
